// File: rtl/pipe_debug_pkg.sv
// Shared encodings for the UART-driven pipeline debug controller:
// FSM states, host command bytes and dump reason codes.
package pipe_debug_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARG,
        ST_CHECK,
        ST_PULSE_HI,
        ST_PULSE_LO,
        ST_RST,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } state_e;

    typedef enum logic {
        MODE_RUN,
        MODE_CONT
    } mode_e;

    // Host commands are plain ASCII characters.
    localparam logic [7:0] CMD_STEP   = 8'h73; // 's'
    localparam logic [7:0] CMD_RUN_N  = 8'h6E; // 'n'
    localparam logic [7:0] CMD_CONT   = 8'h63; // 'c'
    localparam logic [7:0] CMD_BP_SET = 8'h62; // 'b'
    localparam logic [7:0] CMD_BP_CLR = 8'h42; // 'B'
    localparam logic [7:0] CMD_RESET  = 8'h72; // 'r'
    localparam logic [7:0] CMD_HALT   = 8'h68; // 'h'

    localparam logic [7:0] RSN_STEP  = 8'h01;
    localparam logic [7:0] RSN_RUN_N = 8'h02;
    localparam logic [7:0] RSN_HALT  = 8'h03;
    localparam logic [7:0] RSN_BREAK = 8'h04;
    localparam logic [7:0] RSN_USER  = 8'h05;

endpackage

// File: rtl/debug_dump_shifter.sv
// Snapshot buffer for one dump: holds the wide debug bus and hands it out
// one byte at a time behind the reason byte.
module debug_dump_shifter #(
    parameter int DUMP_BYTES = 172
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [7:0]              reason_i,
    input  logic [DUMP_BYTES*8-1:0] data_i,
    input  logic                    advance_i,
    output logic [7:0]              tx_byte_o,
    output logic                    last_o
);

    localparam int CNT_W = $clog2(DUMP_BYTES + 1);

    logic [DUMP_BYTES*8-1:0] snap_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [7:0]              byte_q;
    logic                    step;

    assign step = advance_i && (cnt_q != '0);

    // NOTE: the snapshot buffer has no reset; every dump reloads it before its first byte is read.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            snap_q <= data_i;
        end else if (step) begin
            snap_q <= snap_q >> 8;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            byte_q <= '0;
        end else if (load_i) begin
            cnt_q  <= CNT_W'(DUMP_BYTES);
            byte_q <= reason_i;
        end else if (step) begin
            cnt_q  <= cnt_q - 1'b1;
            byte_q <= snap_q[7:0];
        end
    end

    assign tx_byte_o = byte_q;
    assign last_o    = (cnt_q == '0);

endmodule

// File: rtl/pipe_debug_ctrl.sv
// Host-driven debug controller: steps/runs the pipeline clock, handles
// breakpoints and halts, and returns a framed snapshot over the UART.
module pipe_debug_ctrl
    import pipe_debug_pkg::*;
#(
    parameter int          DUMP_BYTES  = 172,
    parameter logic [31:0] HALT_INSTR  = 32'hFC000000,
    parameter int          HALT_REPEAT = 4
) (
    input  logic                    top_clk,
    input  logic                    top_rst,
    input  logic                    rx_done_tick,
    input  logic [7:0]              rx_bus,
    input  logic                    tx_done_tick,
    input  logic [31:0]             instruccion,
    input  logic [31:0]             pc,
    input  logic [DUMP_BYTES*8-1:0] send_data,
    output logic                    clk_pipe,
    output logic                    rst_pipe,
    output logic                    tx_start,
    output logic [7:0]              tx_bus,
    output logic                    busy
);

    localparam int HALT_CNT_W = $clog2(HALT_REPEAT + 1);

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [7:0]            run_reason_q, run_reason_d;
    logic [7:0]            count_q, count_d;
    logic [7:0]            reason_q, reason_d;
    logic [HALT_CNT_W-1:0] halt_cnt_q, halt_cnt_d, halt_next;
    logic                  halt_req_q, halt_req_d;
    logic                  first_chk_q, first_chk_d;
    logic                  bp_en_q, bp_en_d;
    logic [31:0]           bp_addr_q, bp_addr_d;
    logic [1:0]            arg_cnt_q, arg_cnt_d;
    logic                  arg_bp_q, arg_bp_d;
    logic                  rst_cnt_q, rst_cnt_d;
    logic                  clk_pipe_q, rst_pipe_q, tx_start_q, busy_q;
    logic                  dump_load, dump_adv, dump_last, rx_halt;

    assign rx_halt   = rx_done_tick && (rx_bus == CMD_HALT);
    assign halt_next = (instruccion == HALT_INSTR) ? halt_cnt_q + 1'b1 : '0;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        run_reason_d = run_reason_q;
        count_d      = count_q;
        reason_d     = reason_q;
        halt_cnt_d   = halt_cnt_q;
        halt_req_d   = halt_req_q;
        first_chk_d  = first_chk_q;
        bp_en_d      = bp_en_q;
        bp_addr_d    = bp_addr_q;
        arg_cnt_d    = arg_cnt_q;
        arg_bp_d     = arg_bp_q;
        rst_cnt_d    = rst_cnt_q;
        dump_load    = 1'b0;
        dump_adv     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_done_tick) begin
                    case (rx_bus)
                        CMD_STEP: begin
                            mode_d       = MODE_RUN;
                            run_reason_d = RSN_STEP;
                            count_d      = 8'd1;
                            state_d      = ST_CHECK;
                        end
                        CMD_RUN_N: begin
                            arg_bp_d  = 1'b0;
                            arg_cnt_d = '0;
                            state_d   = ST_ARG;
                        end
                        CMD_CONT: begin
                            mode_d      = MODE_CONT;
                            halt_cnt_d  = '0;
                            halt_req_d  = 1'b0;
                            first_chk_d = 1'b1;
                            state_d     = ST_CHECK;
                        end
                        CMD_BP_SET: begin
                            arg_bp_d  = 1'b1;
                            arg_cnt_d = '0;
                            state_d   = ST_ARG;
                        end
                        CMD_BP_CLR: bp_en_d = 1'b0;
                        CMD_RESET: begin
                            rst_cnt_d = 1'b0;
                            state_d   = ST_RST;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ARG: begin
                if (rx_done_tick) begin
                    if (arg_bp_q) begin
                        // Breakpoint address arrives little-endian.
                        bp_addr_d[{arg_cnt_q, 3'b000} +: 8] = rx_bus;
                        arg_cnt_d = arg_cnt_q + 1'b1;
                        if (arg_cnt_q == 2'd3) begin
                            bp_en_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (rx_bus == 8'd0) begin
                        reason_d = RSN_RUN_N;
                        state_d  = ST_LOAD;
                    end else begin
                        mode_d       = MODE_RUN;
                        run_reason_d = RSN_RUN_N;
                        count_d      = rx_bus;
                        state_d      = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (mode_q == MODE_CONT) begin
                    first_chk_d = 1'b0;
                    halt_cnt_d  = halt_next;
                    if (rx_halt || halt_req_q) begin
                        reason_d   = RSN_USER;
                        halt_req_d = 1'b0;
                        state_d    = ST_LOAD;
                    end else if (bp_en_q && (pc == bp_addr_q) && !first_chk_q) begin
                        reason_d = RSN_BREAK;
                        state_d  = ST_LOAD;
                    end else if (halt_next == HALT_CNT_W'(HALT_REPEAT)) begin
                        reason_d = RSN_HALT;
                        state_d  = ST_LOAD;
                    end else begin
                        state_d = ST_PULSE_HI;
                    end
                end else if (count_q == 8'd0) begin
                    reason_d = run_reason_q;
                    state_d  = ST_LOAD;
                end else begin
                    count_d = count_q - 8'd1;
                    state_d = ST_PULSE_HI;
                end
            end
            ST_PULSE_HI, ST_PULSE_LO: begin
                // A halt request landing between checks is held for the next one.
                if ((mode_q == MODE_CONT) && rx_halt) begin
                    halt_req_d = 1'b1;
                end
                state_d = (state_q == ST_PULSE_HI) ? ST_PULSE_LO : ST_CHECK;
            end
            ST_RST: begin
                halt_cnt_d = '0;
                rst_cnt_d  = 1'b1;
                if (rst_cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                dump_load = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done_tick) begin
                    if (dump_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        dump_adv = 1'b1;
                        state_d  = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge top_clk or posedge top_rst) begin
        if (top_rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_RUN;
            run_reason_q <= '0;
            count_q      <= '0;
            reason_q     <= '0;
            halt_cnt_q   <= '0;
            halt_req_q   <= 1'b0;
            first_chk_q  <= 1'b0;
            bp_en_q      <= 1'b0;
            bp_addr_q    <= '0;
            arg_cnt_q    <= '0;
            arg_bp_q     <= 1'b0;
            rst_cnt_q    <= 1'b0;
            clk_pipe_q   <= 1'b0;
            rst_pipe_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            run_reason_q <= run_reason_d;
            count_q      <= count_d;
            reason_q     <= reason_d;
            halt_cnt_q   <= halt_cnt_d;
            halt_req_q   <= halt_req_d;
            first_chk_q  <= first_chk_d;
            bp_en_q      <= bp_en_d;
            bp_addr_q    <= bp_addr_d;
            arg_cnt_q    <= arg_cnt_d;
            arg_bp_q     <= arg_bp_d;
            rst_cnt_q    <= rst_cnt_d;
            // Outputs are registered from the next state so the generated clock never glitches.
            clk_pipe_q   <= (state_d == ST_PULSE_HI);
            rst_pipe_q   <= (state_d == ST_RST);
            tx_start_q   <= (state_d == ST_SEND);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    debug_dump_shifter #(
        .DUMP_BYTES (DUMP_BYTES)
    ) u_shifter (
        .clk_i     (top_clk),
        .rst_i     (top_rst),
        .load_i    (dump_load),
        .reason_i  (reason_q),
        .data_i    (send_data),
        .advance_i (dump_adv),
        .tx_byte_o (tx_bus),
        .last_o    (dump_last)
    );

    assign clk_pipe = clk_pipe_q;
    assign rst_pipe = rst_pipe_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// Directed bench for pipe_debug_ctrl: host commands in, expected dump bytes
// queued at command time and compared as the UART handshake drains them.
module tb_pipe_debug_ctrl;

    localparam int          DB   = 172;
    localparam logic [31:0] HALT = 32'hFC000000;

    logic            top_clk = 1'b0;
    logic            top_rst = 1'b0;
    logic            rx_done_tick = 1'b0;
    logic [7:0]      rx_bus = 8'h00;
    logic            tx_done_tick = 1'b0;
    logic [31:0]     instruccion = 32'h0;
    logic [31:0]     pc;
    logic [DB*8-1:0] send_data = '0;
    logic            clk_pipe, rst_pipe, tx_start, busy;
    logic [7:0]      tx_bus;

    pipe_debug_ctrl #(
        .DUMP_BYTES  (DB),
        .HALT_INSTR  (HALT),
        .HALT_REPEAT (4)
    ) dut (
        .top_clk      (top_clk),
        .top_rst      (top_rst),
        .rx_done_tick (rx_done_tick),
        .rx_bus       (rx_bus),
        .tx_done_tick (tx_done_tick),
        .instruccion  (instruccion),
        .pc           (pc),
        .send_data    (send_data),
        .clk_pipe     (clk_pipe),
        .rst_pipe     (rst_pipe),
        .tx_start     (tx_start),
        .tx_bus       (tx_bus),
        .busy         (busy)
    );

    always #5 top_clk = ~top_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_total = 0;
    int txs_total = 0;
    int last_pulse_cyc = -100;
    int close_pulses = 0;
    int b2b_tx = 0;
    logic prev_tx = 1'b0;
    logic [31:0] pc_off = 32'h0;
    logic [7:0] exp_q[$];

    // The observed pipeline stage advances its PC by 4 per generated clock.
    assign pc = pc_off + (32'(pulse_total) << 2);

    always @(negedge top_clk) begin
        cyc <= cyc + 1;
        if (clk_pipe) begin
            pulse_total <= pulse_total + 1;
            if (cyc - last_pulse_cyc < 3) close_pulses <= close_pulses + 1;
            last_pulse_cyc <= cyc;
        end
        if (tx_start) begin
            txs_total <= txs_total + 1;
            if (prev_tx) b2b_tx <= b2b_tx + 1;
        end
        prev_tx <= tx_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge top_clk);
        rx_bus = b;
        rx_done_tick = 1'b1;
        @(negedge top_clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic randomize_snapshot();
        for (int w = 0; w < DB / 4; w++) send_data[32*w +: 32] = $urandom();
    endtask

    task automatic push_frame(input logic [7:0] reason);
        exp_q.push_back(reason);
        for (int i = 0; i < DB; i++) exp_q.push_back(send_data[8*i +: 8]);
    endtask

    task automatic wait_pulse(input string tag, output int c);
        c = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge top_clk);
            if (clk_pipe === 1'b1) begin
                c = cyc;
                return;
            end
        end
        timeout_fail(tag);
    endtask

    // Drains the expected queue through the tx handshake; stop_at >= 0 returns
    // right after byte stop_at is compared, leaving the frame unfinished.
    task automatic serve_frame(input string tag, input int stop_at);
        int idx = 0;
        bit ok;
        logic [7:0] exp_b;
        while (exp_q.size() > 0) begin
            ok = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                if (tx_start === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge top_clk);
            end
            if (!ok) begin
                timeout_fail({tag, " tx_start"});
                exp_q.delete();
                return;
            end
            exp_b = exp_q.pop_front();
            check($sformatf("%s byte %0d", tag, idx), 32'(tx_bus), 32'(exp_b));
            if (idx == 0) randomize_snapshot();
            if (idx == stop_at) return;
            repeat (2) @(negedge top_clk);
            check($sformatf("%s hold %0d", tag, idx), 32'(tx_bus), 32'(exp_b));
            tx_done_tick = 1'b1;
            @(negedge top_clk);
            tx_done_tick = 1'b0;
            idx++;
        end
        check({tag, " busy after frame"}, 32'(busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " clk_pipe"}, 32'(clk_pipe), 32'd0);
        check({tag, " rst_pipe"}, 32'(rst_pipe), 32'd0);
        check({tag, " tx_start"}, 32'(tx_start), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " tx_bus"}, 32'(tx_bus), 32'd0);
    endtask

    initial begin
        int base_p, base_tx, c, prev_c, rcnt;

        #1 top_rst = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge top_clk);
        top_rst = 1'b0;

        // Single step
        randomize_snapshot();
        base_p = pulse_total; base_tx = txs_total;
        push_frame(8'h01);
        send_byte(8'h73);
        check("step busy", 32'(busy), 32'd1);
        serve_frame("step", -1);
        check("step pulses", 32'(pulse_total - base_p), 32'd1);
        check("step tx count", 32'(txs_total - base_tx), 32'd173);

        // Unknown command byte
        base_tx = txs_total;
        send_byte(8'h78);
        repeat (4) @(negedge top_clk);
        check("unknown busy", 32'(busy), 32'd0);
        check("unknown tx", 32'(txs_total - base_tx), 32'd0);

        // Run N = 5, pulses three top_clk cycles apart
        base_p = pulse_total;
        push_frame(8'h02);
        send_byte(8'h6E);
        send_byte(8'h05);
        wait_pulse("run5 p0", prev_c);
        for (int k = 1; k < 5; k++) begin
            wait_pulse("run5 pulse", c);
            check($sformatf("run5 gap %0d", k), 32'(c - prev_c), 32'd3);
            prev_c = c;
        end
        serve_frame("run5", -1);
        check("run5 pulses", 32'(pulse_total - base_p), 32'd5);

        // Run N = 0 dumps at once
        base_p = pulse_total;
        push_frame(8'h02);
        send_byte(8'h6E);
        send_byte(8'h00);
        serve_frame("run0", -1);
        check("run0 pulses", 32'(pulse_total - base_p), 32'd0);

        // Continue until four consecutive halt instructions
        instruccion = 32'h0;
        base_p = pulse_total;
        push_frame(8'h03);
        send_byte(8'h63);
        for (int k = 0; k < 3; k++) wait_pulse("halt wait", c);
        instruccion = HALT;
        serve_frame("halt", -1);
        check("halt pulses", 32'(pulse_total - base_p), 32'd6);
        instruccion = 32'h0;

        // Breakpoint at 0x10
        base_tx = txs_total;
        send_byte(8'h62);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (2) @(negedge top_clk);
        check("bp set busy", 32'(busy), 32'd0);
        check("bp set tx", 32'(txs_total - base_tx), 32'd0);
        pc_off = 32'h0 - (32'(pulse_total) << 2);
        base_p = pulse_total;
        push_frame(8'h04);
        send_byte(8'h63);
        serve_frame("bp", -1);
        check("bp pulses", 32'(pulse_total - base_p), 32'd4);
        check("bp pc", pc, 32'h10);

        // Continue again from the breakpoint address must leave it
        base_p = pulse_total;
        push_frame(8'h05);
        send_byte(8'h63);
        for (int k = 0; k < 2; k++) wait_pulse("bp leave", c);
        send_byte(8'h68);
        serve_frame("bp leave", -1);
        check("bp leave moved", 32'(pulse_total - base_p >= 1), 32'd1);

        // Cleared breakpoint is passed without stopping
        send_byte(8'h42);
        pc_off = 32'h0 - (32'(pulse_total) << 2);
        base_p = pulse_total;
        push_frame(8'h05);
        send_byte(8'h63);
        for (int k = 0; k < 8; k++) wait_pulse("bp clear", c);
        send_byte(8'h68);
        serve_frame("bp clear", -1);
        check("bp clear passed", 32'(pulse_total - base_p >= 8), 32'd1);

        // User halt in the same check as the fourth halt match
        base_p = pulse_total;
        push_frame(8'h05);
        send_byte(8'h63);
        wait_pulse("user p1", c);
        instruccion = HALT;
        for (int k = 0; k < 3; k++) wait_pulse("user p", c);
        @(negedge top_clk);
        @(negedge top_clk);
        rx_bus = 8'h68;
        rx_done_tick = 1'b1;
        @(negedge top_clk);
        rx_done_tick = 1'b0;
        serve_frame("user halt", -1);
        check("user halt pulses", 32'(pulse_total - base_p), 32'd4);
        instruccion = 32'h0;

        // Pipeline reset
        base_tx = txs_total;
        rcnt = 0;
        send_byte(8'h72);
        for (int k = 0; k < 8; k++) begin
            if (rst_pipe === 1'b1) rcnt++;
            @(negedge top_clk);
        end
        check("rst cycles", 32'(rcnt), 32'd2);
        check("rst busy", 32'(busy), 32'd0);
        check("rst tx", 32'(txs_total - base_tx), 32'd0);

        // Async reset in the middle of a dump, then a fresh full frame
        push_frame(8'h01);
        send_byte(8'h73);
        serve_frame("pre reset", 50);
        #2 top_rst = 1'b1;
        #1 check_outputs_zero("mid dump reset");
        exp_q.delete();
        @(negedge top_clk);
        top_rst = 1'b0;
        base_tx = txs_total;
        base_p = pulse_total;
        push_frame(8'h01);
        send_byte(8'h73);
        serve_frame("after reset", -1);
        check("after reset tx count", 32'(txs_total - base_tx), 32'd173);
        check("after reset pulses", 32'(pulse_total - base_p), 32'd1);

        repeat (4) @(negedge top_clk);
        check("pulse spacing", 32'(close_pulses), 32'd0);
        check("tx_start back to back", 32'(b2b_tx), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_debug_ctrl.md
Name: pipe_debug_ctrl

Overview:
- UART-driven debug controller for the pipeline; generalised successor of the original single-step/continue debug unit.
- Generates the pipeline clock and reset from host commands: step, run-N, continue-until-halt, breakpoint and user halt.
- Returns a framed snapshot of a parametrised-width debug bus over the UART TX handshake.
- Sits between the UART rx/tx cores and the pipeline top.

Parameters:
DUMP_BYTES, 172, number of snapshot bytes sent per dump; send_data width = DUMP_BYTES*8
HALT_INSTR, 32'hFC000000, instruction word that signals program end
HALT_REPEAT, 4, consecutive checks with instruccion==HALT_INSTR needed to stop a continue

Ports:
top_clk  in  1  system clock
top_rst  in  1  asynchronous active-high reset
rx_done_tick  in  1  one-cycle strobe, rx_bus valid
rx_bus  in  8  received byte
tx_done_tick  in  1  one-cycle strobe, UART finished current byte
instruccion  in  32  instruction currently in the observed pipeline stage
pc  in  32  program counter of the observed stage
send_data  in  DUMP_BYTES*8  debug snapshot bus
clk_pipe  out  1  generated pipeline clock
rst_pipe  out  1  pipeline reset
tx_start  out  1  one-cycle strobe, send tx_bus
tx_bus  out  8  byte to transmit
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): clk_pipe, rst_pipe, tx_start, busy = 0; tx_bus = 0; state IDLE; halt counter 0; bp_en 0; bp_addr 0; argument counter 0. A dump in progress is abandoned.
- States: IDLE, ARG, CHECK, PULSE_HI, PULSE_LO, RST, LOAD, SEND, WAIT.
- IDLE: acts only on rx_done_tick. Unknown bytes are ignored.
  - 's': run count = 1; go to CHECK in run-N mode.
  - 'n': go to ARG to collect 1 byte N. N = 0 dumps immediately with reason 0x02. Otherwise run-N mode with count N.
  - 'c': continue mode; halt counter cleared.
  - 'b': go to ARG to collect 4 bytes, little-endian, into bp_addr; then bp_en = 1; return to IDLE with no transmission.
  - 'B': bp_en = 0.
  - 'r': go to RST.
- ARG: each rx_done_tick consumes one byte as an argument, whatever its value. No timeout.
- CHECK (continue mode): evaluate stop conditions, highest priority first:
  - 'h' received this cycle -> reason 0x05
  - bp_en and pc == bp_addr, skipped on the first CHECK after 'c' so a continue can leave a breakpoint -> reason 0x04
  - halt counter == HALT_REPEAT -> reason 0x03
  - Halt counter increments when instruccion == HALT_INSTR and clears otherwise.
  - On a stop condition go to LOAD; otherwise go to PULSE_HI.
- CHECK (run-N mode): count == 0 -> LOAD with reason 0x01 (s) or 0x02 (n); else decrement count, then PULSE_HI.
- PULSE_HI: clk_pipe = 1 for exactly one top_clk cycle. PULSE_LO: clk_pipe = 0 for one cycle, then CHECK. One pipeline clock therefore costs 3 top_clk cycles.
- RST: rst_pipe = 1 for exactly 2 top_clk cycles, then IDLE. Halt counter cleared; bp_addr and bp_en retained; nothing transmitted.
- LOAD: latch send_data into the shift buffer and load tx_bus = reason byte in the same cycle; byte counter = DUMP_BYTES.
- Frame on the wire: reason byte, then buffer bytes LSB first (send_data[7:0] first). Total DUMP_BYTES+1 bytes.
- SEND: tx_start = 1 for one cycle, then WAIT.
- WAIT: hold tx_bus stable. On tx_done_tick:
  - byte counter > 0: put next byte on tx_bus, decrement counter, go to SEND.
  - byte counter == 0: go to IDLE.
- tx_start is never high in two consecutive cycles.
- rx bytes are ignored while in RST, LOAD, SEND or WAIT, and in run-N mode. In continue mode only 'h' has effect.
- tx_done_tick outside WAIT is ignored.
- Byte counter width = clog2(DUMP_BYTES+1).

Decomposition:
- Shared package pipe_debug_pkg holds: state encodings, command byte constants ('s','n','c','b','B','r','h'), reason codes 0x01–0x05.
- One sub-module, debug_dump_shifter: wide load register, 8-bit shift-out, byte counter, last-byte flag.

Test Plan:
- 's' -> exactly one clk_pipe high cycle, then 173 tx_start pulses; first tx_bus = 0x01; second tx_bus = send_data[7:0]; last = send_data[1375:1368].
- 'n', 0x05 -> 5 clk_pipe pulses 3 cycles apart, reason 0x02. 'n', 0x00 -> zero pulses, immediate dump with reason 0x02.
- 'c' with instruccion = 32'hFC000000 from pulse 3 onward -> stop after 4 consecutive matches, reason 0x03, busy drops after the last tx_done_tick.
- 'b',0x10,0x00,0x00,0x00 then 'c', pc reaching 0x10 -> reason 0x04. A second 'c' while pc==0x10 still produces at least one pulse. 'B' then 'c' -> no breakpoint stop.
- 'c' then 'h' mid-run, with HALT_INSTR arriving in the same cycle -> reason 0x05. 'r' -> rst_pipe high exactly 2 cycles, no transmission.
- top_rst asserted mid-dump (byte 50) -> all outputs 0 immediately, IDLE. A following 's' produces a fresh full 173-byte frame.
